// File: rtl/tpu_pkg.sv
// Shared widths and saturation-bound helpers for the systolic array datapath.
package tpu_pkg;

  localparam int unsigned DefActW = 8;
  localparam int unsigned DefWgtW = 8;
  localparam int unsigned DefAccW = 24;

  // Helpers return a wide bit pattern; callers keep the low 'width' bits.
  localparam int unsigned SatFnW = 64;

  function automatic logic [SatFnW-1:0] sat_max(input int unsigned width, input bit is_signed);
    if (is_signed) begin
      return (SatFnW'(1) << (width - 1)) - SatFnW'(1);
    end
    return (SatFnW'(1) << width) - SatFnW'(1);
  endfunction

  function automatic logic [SatFnW-1:0] sat_min(input int unsigned width, input bit is_signed);
    if (is_signed) begin
      return SatFnW'(1) << (width - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/pe_mul_add.sv
// Combinational core of the PE: extend, multiply, accumulate, detect overflow, optionally clamp.
module pe_mul_add
  import tpu_pkg::*;
#(
  parameter int unsigned ACT_W    = DefActW,
  parameter int unsigned WGT_W    = DefWgtW,
  parameter int unsigned ACC_W    = DefAccW,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [ACT_W-1:0] act,
  input  logic [WGT_W-1:0] wgt,
  input  logic [ACC_W-1:0] psum,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam int unsigned ProdW = ACT_W + WGT_W;

  localparam logic [SatFnW-1:0] SatHiFull = sat_max(ACC_W, SIGNED);
  localparam logic [SatFnW-1:0] SatLoFull = sat_min(ACC_W, SIGNED);
  localparam logic [ACC_W-1:0]  SatHi     = SatHiFull[ACC_W-1:0];
  localparam logic [ACC_W-1:0]  SatLo     = SatLoFull[ACC_W-1:0];

  logic [ProdW-1:0] act_ext;
  logic [ProdW-1:0] wgt_ext;
  logic [ProdW-1:0] prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_wide;

  always_comb begin
    if (SIGNED) begin
      act_ext  = ProdW'($signed(act));
      wgt_ext  = ProdW'($signed(wgt));
    end else begin
      act_ext  = ProdW'(act);
      wgt_ext  = ProdW'(wgt);
    end
    // Low ProdW bits of the product are exact for both encodings.
    prod = act_ext * wgt_ext;
    if (SIGNED) begin
      prod_ext = ACC_W'($signed(prod));
    end else begin
      prod_ext = ACC_W'(prod);
    end
    sum_wide = {1'b0, psum} + {1'b0, prod_ext};

    if (SIGNED) begin
      ovf = (psum[ACC_W-1] == prod_ext[ACC_W-1]) && (sum_wide[ACC_W-1] != psum[ACC_W-1]);
    end else begin
      ovf = sum_wide[ACC_W];
    end

    sum = sum_wide[ACC_W-1:0];
    if (SATURATE && ovf) begin
      // Signed overflow direction follows the shared operand sign.
      if (SIGNED && psum[ACC_W-1]) begin
        sum = SatLo;
      end else begin
        sum = SatHi;
      end
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// Weight-stationary systolic processing element with double-buffered weight and sticky overflow.
module systolic_pe
  import tpu_pkg::*;
#(
  parameter int unsigned ACT_W    = DefActW,
  parameter int unsigned WGT_W    = DefWgtW,
  parameter int unsigned ACC_W    = DefAccW,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wgt_shift,
  input  logic [WGT_W-1:0] wgt_in,
  output logic [WGT_W-1:0] wgt_out,
  input  logic             wgt_commit,
  input  logic             valid_in,
  input  logic [ACT_W-1:0] act_in,
  input  logic [ACC_W-1:0] psum_in,
  output logic             valid_out,
  output logic [ACT_W-1:0] act_out,
  output logic [ACC_W-1:0] psum_out,
  input  logic             ovf_clr,
  output logic             ovf
);

  if (ACC_W < ACT_W + WGT_W) begin : g_bad_width
    $error("systolic_pe: ACC_W must be >= ACT_W + WGT_W");
  end

  logic [WGT_W-1:0] shadow_q, shadow_d;
  logic [WGT_W-1:0] active_q, active_d;
  logic [ACT_W-1:0] act_q, act_d;
  logic [ACC_W-1:0] psum_q, psum_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum;
  logic             sum_ovf;

  pe_mul_add #(
    .ACT_W    (ACT_W),
    .WGT_W    (WGT_W),
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_mul_add (
    .act  (act_in),
    .wgt  (active_q),
    .psum (psum_in),
    .sum  (sum),
    .ovf  (sum_ovf)
  );

  always_comb begin
    shadow_d = wgt_shift  ? wgt_in   : shadow_q;
    // Commit takes the pre-shift shadow, so commit+shift in one cycle is safe.
    active_d = wgt_commit ? shadow_q : active_q;
    act_d    = valid_in   ? act_in   : act_q;
    psum_d   = valid_in   ? sum      : psum_q;
    valid_d  = valid_in;
    if (valid_in && sum_ovf) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      act_q    <= '0;
      psum_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      act_q    <= act_d;
      psum_q   <= psum_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wgt_out   = shadow_q;
  assign act_out   = act_q;
  assign psum_out  = psum_q;
  assign valid_out = valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Randomised bench for systolic_pe: four parameter variants share stimulus against an integer model.
module tb_systolic_pe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wgt_shift = 1'b0;
  logic [7:0]  wgt_in = '0;
  logic        wgt_commit = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  act_in = '0;
  logic [23:0] psum_in = '0;
  logic        ovf_clr = 1'b0;

  logic [7:0]  wgt_o   [4];
  logic [7:0]  act_o   [4];
  logic [23:0] psum_o  [4];
  logic        valid_o [4];
  logic        ovf_o   [4];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  // Variant g: bit 1 selects signed arithmetic, bit 0 selects saturation.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    systolic_pe #(
      .ACT_W    (8),
      .WGT_W    (8),
      .ACC_W    (24),
      .SIGNED   (bit'(g / 2)),
      .SATURATE (bit'(g % 2))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wgt_shift  (wgt_shift),
      .wgt_in     (wgt_in),
      .wgt_out    (wgt_o[g]),
      .wgt_commit (wgt_commit),
      .valid_in   (valid_in),
      .act_in     (act_in),
      .psum_in    (psum_in),
      .valid_out  (valid_o[g]),
      .act_out    (act_o[g]),
      .psum_out   (psum_o[g]),
      .ovf_clr    (ovf_clr),
      .ovf        (ovf_o[g])
    );
  end

  // Reference state
  logic [7:0]  m_shadow, m_active, m_act;
  logic        m_valid;
  logic [23:0] m_psum [4];
  logic        m_ovf  [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Arithmetic reference: exact integer result, then range test and clamp/wrap.
  task automatic model_edge();
    longint a, w, p, s, lo, hi;
    bit     sg, st, o;
    if (!rst_n) begin
      m_shadow = '0; m_active = '0; m_act = '0; m_valid = 1'b0;
      for (int g = 0; g < 4; g++) begin
        m_psum[g] = '0;
        m_ovf[g]  = 1'b0;
      end
      return;
    end
    for (int g = 0; g < 4; g++) begin
      sg = (g / 2) == 1;
      st = (g % 2) == 1;
      a  = sg ? longint'($signed(act_in))   : longint'(act_in);
      w  = sg ? longint'($signed(m_active)) : longint'(m_active);
      p  = sg ? longint'($signed(psum_in))  : longint'(psum_in);
      s  = p + a * w;
      lo = sg ? -(longint'(1) <<< 23) : 0;
      hi = sg ? (longint'(1) <<< 23) - 1 : (longint'(1) <<< 24) - 1;
      o  = (s < lo) || (s > hi);
      if (valid_in) begin
        if (o && st) m_psum[g] = (s > hi) ? 24'(hi) : 24'(lo);
        else         m_psum[g] = 24'(s);
      end
      if (valid_in && o) m_ovf[g] = 1'b1;
      else if (ovf_clr)  m_ovf[g] = 1'b0;
    end
    if (valid_in) m_act = act_in;
    m_valid = valid_in;
    if (wgt_commit) m_active = m_shadow;
    if (wgt_shift)  m_shadow = wgt_in;
  endtask

  task automatic check_all();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("wgt_out[%0d]", g),   wgt_o[g],   m_shadow);
      chk($sformatf("valid_out[%0d]", g), valid_o[g], m_valid);
      chk($sformatf("act_out[%0d]", g),   act_o[g],   m_act);
      chk($sformatf("psum_out[%0d]", g),  psum_o[g],  m_psum[g]);
      chk($sformatf("ovf[%0d]", g),       ovf_o[g],   m_ovf[g]);
    end
  endtask

  task automatic step(input bit rn, input bit sh, input logic [7:0] wi, input bit cm,
                      input bit v, input logic [7:0] a, input logic [23:0] p, input bit clr);
    rst_n = rn; wgt_shift = sh; wgt_in = wi; wgt_commit = cm;
    valid_in = v; act_in = a; psum_in = p; ovf_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load_weight(input logic [7:0] w);
    step(1, 1, w, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0]  r_w, r_a;
    logic [23:0] r_p;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_psum", psum_o[0], 24'h0);

    // Load and first compute
    load_weight(8'h05);
    step(1, 0, 0, 0, 1, 8'd3, 24'd10, 0);
    chk("load_psum", psum_o[0], 24'd25);
    chk("load_act", act_o[0], 8'd3);
    chk("load_valid", valid_o[0], 1'b1);

    // Double buffer: shift while streaming; commit-cycle product uses old weight
    load_weight(8'h02);
    step(1, 1, 8'h07, 0, 1, 8'd4, 24'd0, 0);
    chk("dbuf_pre", psum_o[0], 24'd8);
    step(1, 0, 0, 1, 1, 8'd4, 24'd0, 0);
    chk("dbuf_commit_cycle", psum_o[0], 24'd8);
    step(1, 0, 0, 0, 1, 8'd4, 24'd0, 0);
    chk("dbuf_post", psum_o[0], 24'd28);
    step(1, 1, 8'h09, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 8'd4, 24'd0, 0);
    chk("commit_old_shadow", psum_o[0], 24'd28);

    // Unsigned wrap vs saturate
    load_weight(8'hFF);
    step(1, 0, 0, 0, 1, 8'hFF, 24'hFFFFFF, 0);
    chk("uwrap_psum", psum_o[0], 24'h00FE00);
    chk("uwrap_ovf", ovf_o[0], 1'b1);
    chk("usat_psum", psum_o[1], 24'hFFFFFF);
    chk("usat_ovf", ovf_o[1], 1'b1);

    // Signed cases
    step(1, 0, 0, 0, 0, 0, 0, 1);
    load_weight(8'hFE);
    step(1, 0, 0, 0, 1, 8'd100, 24'h7FFFFF, 0);
    chk("swrap_psum", psum_o[2], 24'h7FFF37);
    chk("swrap_ovf", ovf_o[2], 1'b0);
    step(1, 0, 0, 0, 1, 8'd1, 24'h800000, 0);
    chk("ssat_psum", psum_o[3], 24'h800000);
    chk("ssat_ovf", ovf_o[3], 1'b1);

    // Bubbles hold outputs
    repeat (3) step(1, 0, 0, 0, 0, 8'hAA, 24'h123456, 0);
    chk("bubble_psum", psum_o[3], 24'h800000);
    chk("bubble_valid", valid_o[3], 1'b0);

    // Set beats clear
    step(1, 0, 0, 0, 1, 8'd1, 24'h800000, 1);
    chk("set_over_clr", ovf_o[3], 1'b1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_ovf", ovf_o[3], 1'b0);

    // Reset mid-stream
    load_weight(8'h11);
    repeat (3) step(1, 0, 0, 0, 1, 8'($urandom), 24'($urandom), 0);
    step(0, 0, 0, 0, 1, 8'h22, 24'h555, 0);
    chk("midrst_psum", psum_o[0], 24'h0);
    chk("midrst_valid", valid_o[0], 1'b0);
    step(1, 0, 0, 0, 1, 8'h33, 24'h001234, 0);
    chk("postrst_psum", psum_o[0], 24'h001234);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r_w = 8'($urandom);
      r_a = 8'($urandom);
      r_p = 24'($urandom);
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) == 0), r_w,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0), r_a, r_p,
           ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
